// File: rtl/if_prefetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package if_prefetch_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  localparam word_t NOP_INST_DEFAULT = 16'h0000;

  // Sequential fetch address; wraps FFFF -> 0000 naturally.
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + 16'h0001;
  endfunction

endpackage

// File: rtl/if_prefetch_inst_fifo.sv
// First-word fall-through FIFO of {inst, pc_added} entries with synchronous flush.
module if_prefetch_inst_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [31:0]                head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify push/pop against occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);
  end

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = (count_r != {CW{1'b0}});
  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem request FSM,
// and a prefetch FIFO feeding IF/ID; redirects flush and drop in-flight reads.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter addr_t RESET_PC = 16'h0000,
  parameter word_t NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst_out,
  output logic [15:0] pc_added_out
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e  state_r, state_s;
  addr_t         fpc_r, fpc_s;
  addr_t         drop_addr_r, drop_addr_s;
  logic          req_s;
  addr_t         addr_s;
  logic          push_s, pop_s, flush_s;
  logic          fifo_valid_s;
  logic [31:0]   fifo_head_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_full_s;

  assign fifo_full_s = (fifo_count_s == CW'(DEPTH));

  // Request generation: a dropped read keeps its address until its ack arrives.
  always_comb begin
    req_s  = 1'b0;
    addr_s = fpc_r;
    case (state_r)
      FETCH: begin
        req_s  = !fifo_full_s;
        addr_s = fpc_r;
      end
      DROP: begin
        req_s  = 1'b1;
        addr_s = drop_addr_r;
      end
      default: begin
        req_s  = 1'b0;
        addr_s = fpc_r;
      end
    endcase
  end

  // Next-state, PC update and FIFO control; redirect overrides push and pop.
  always_comb begin
    state_s     = state_r;
    fpc_s       = fpc_r;
    drop_addr_s = drop_addr_r;
    push_s      = 1'b0;
    flush_s     = redirect;
    pop_s       = fifo_valid_s && !stall && !redirect;
    case (state_r)
      FETCH: begin
        if (redirect) begin
          fpc_s = redirect_pc;
          if (req_s && !imem_ack) begin
            state_s     = DROP;
            drop_addr_s = fpc_r;
          end else begin
            state_s = FETCH;
          end
        end else if (req_s && imem_ack) begin
          push_s = 1'b1;
          fpc_s  = pc_inc(fpc_r);
        end else begin
          fpc_s = fpc_r;
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_s = redirect_pc;
        end else begin
          fpc_s = fpc_r;
        end
        if (imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
  end

  // FSM, fetch PC and dropped-request address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= FETCH;
      fpc_r       <= RESET_PC;
      drop_addr_r <= 16'h0000;
    end else begin
      state_r     <= state_s;
      fpc_r       <= fpc_s;
      drop_addr_r <= drop_addr_s;
    end
  end

  if_prefetch_inst_fifo #(
    .DEPTH(DEPTH)
  ) u_inst_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_s),
    .push     (push_s),
    .push_data({imem_rdata, pc_inc(fpc_r)}),
    .pop      (pop_s),
    .valid    (fifo_valid_s),
    .head     (fifo_head_s),
    .count    (fifo_count_s)
  );

  assign imem_req     = req_s && rst;
  assign imem_addr    = addr_s;
  assign inst_valid   = fifo_valid_s;
  assign inst_out     = fifo_valid_s ? fifo_head_s[31:16] : NOP_INST;
  assign pc_added_out = fifo_valid_s ? fifo_head_s[15:0] : 16'h0000;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch with a variable-latency memory model.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect, stall;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        inst_valid;
  logic [15:0] inst_out, pc_added_out;

  logic        w_req, w_ack, w_valid;
  logic [15:0] w_addr, w_rdata, w_inst, w_pc;

  int lat = 0;
  int wait_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: ack after `lat` wait cycles, data = addr ^ A000.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr ^ 16'hA000;
  assign w_ack      = w_req;
  assign w_rdata    = w_addr ^ 16'hA000;

  always @(posedge clk or negedge rst) begin
    if (!rst)                       wait_cnt <= 0;
    else if (imem_req && imem_ack)  wait_cnt <= 0;
    else if (imem_req)              wait_cnt <= wait_cnt + 1;
  end

  if_prefetch #(.DEPTH(4), .RESET_PC(16'h0000), .NOP_INST(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_out(inst_out), .pc_added_out(pc_added_out)
  );

  if_prefetch #(.DEPTH(4), .RESET_PC(16'hFFFE), .NOP_INST(16'h0000)) u_dut_wrap (
    .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(16'h0000),
    .stall(1'b0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_valid(w_valid),
    .inst_out(w_inst), .pc_added_out(w_pc)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    stall       = 1'b0;
    lat         = l;
    #1;
    check_eq("rst_req",   {15'b0, imem_req},   16'h0000);
    check_eq("rst_valid", {15'b0, inst_valid}, 16'h0000);
    check_eq("rst_inst",  inst_out,            16'h0000);
    check_eq("rst_pcadd", pc_added_out,        16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_req(input logic [15:0] a, input string tag);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin
      next_cycle();
      n++;
    end
    check_eq(tag, {15'b0, (imem_req && imem_addr == a)}, 16'h0001);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 40) begin
      next_cycle();
      n++;
    end
    check_eq(tag, {15'b0, inst_valid}, 16'h0001);
  endtask

  initial begin
    logic [15:0] w_exp_inst [3];
    w_exp_inst = '{16'h5FFE, 16'h5FFF, 16'hA000};

    // Zero-wait streaming, plus the FFFE-reset instance wrapping through 0000.
    do_reset(0);
    check_eq("t1_req0",  {15'b0, imem_req},   16'h0001);
    check_eq("t1_addr0", imem_addr,           16'h0000);
    check_eq("t1_val0",  {15'b0, inst_valid}, 16'h0000);
    check_eq("wr_addr0", w_addr,              16'hFFFE);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      check_eq("t1_valid", {15'b0, inst_valid}, 16'h0001);
      check_eq("t1_inst",  inst_out,            16'(16'hA000 + i));
      check_eq("t1_pcadd", pc_added_out,        16'(i + 1));
      check_eq("t1_addr",  imem_addr,           16'(i + 1));
      if (i < 3) begin
        check_eq("wr_inst",  w_inst, w_exp_inst[i]);
        check_eq("wr_pcadd", w_pc,   16'(16'hFFFF + i));
        check_eq("wr_addr",  w_addr, 16'(16'hFFFF + i));
      end
    end

    // Stall for six cycles: FIFO fills, request stops, then resumes at 0004.
    do_reset(0);
    stall = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c >= 2) begin
        check_eq("t2_valid", {15'b0, inst_valid}, 16'h0001);
        check_eq("t2_inst",  inst_out,            16'hA000);
        check_eq("t2_pcadd", pc_added_out,        16'h0001);
      end
      check_eq("t2_req", {15'b0, imem_req}, {15'b0, (c < 5)});
      if (c < 5) check_eq("t2_addr", imem_addr, 16'(c - 1));
      next_cycle();
    end
    stall = 1'b0;
    check_eq("t2_req_full", {15'b0, imem_req}, 16'h0000);
    check_eq("t2_head",     inst_out,          16'hA000);
    next_cycle();
    check_eq("t2_req_res",  {15'b0, imem_req}, 16'h0001);
    check_eq("t2_addr_res", imem_addr,         16'h0004);
    for (int i = 1; i <= 5; i++) begin
      check_eq("t2_seq_inst",  inst_out,     16'(16'hA000 + i));
      check_eq("t2_seq_pcadd", pc_added_out, 16'(i + 1));
      next_cycle();
    end

    // Latency 3, redirect one cycle after the request to 0002 is raised.
    do_reset(3);
    wait_req(16'h0002, "t3_see_0002");
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    check_eq("t3_addr_hold", imem_addr, 16'h0002);
    next_cycle();
    redirect = 1'b0;
    check_eq("t3_drop_valid", {15'b0, inst_valid}, 16'h0000);
    check_eq("t3_drop_req",   {15'b0, imem_req},   16'h0001);
    check_eq("t3_drop_addr",  imem_addr,           16'h0002);
    next_cycle();
    check_eq("t3_drop_addr2", imem_addr,           16'h0002);
    check_eq("t3_drop_ack",   {15'b0, imem_ack},   16'h0001);
    next_cycle();
    check_eq("t3_after_valid", {15'b0, inst_valid}, 16'h0000);
    check_eq("t3_after_addr",  imem_addr,           16'h0040);
    wait_valid("t3_wait_valid");
    check_eq("t3_inst",  inst_out,     16'hA040);
    check_eq("t3_pcadd", pc_added_out, 16'h0041);

    // Redirect coincident with a zero-wait ack: word is discarded, no DROP.
    do_reset(0);
    next_cycle();
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    check_eq("t4_same_valid", {15'b0, inst_valid}, 16'h0001);
    check_eq("t4_same_inst",  inst_out,            16'hA001);
    next_cycle();
    redirect = 1'b0;
    check_eq("t4_valid0", {15'b0, inst_valid}, 16'h0000);
    check_eq("t4_addr",   imem_addr,           16'h0080);
    next_cycle();
    check_eq("t4_inst",  inst_out,     16'hA080);
    check_eq("t4_pcadd", pc_added_out, 16'h0081);

    // Two redirects while a dropped read is still pending: the last one wins.
    do_reset(3);
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    check_eq("t5_addr0", imem_addr, 16'h0000);
    next_cycle();
    redirect_pc = 16'h0200;
    check_eq("t5_drop_addr",  imem_addr,           16'h0000);
    check_eq("t5_drop_valid", {15'b0, inst_valid}, 16'h0000);
    next_cycle();
    redirect = 1'b0;
    check_eq("t5_drop_addr2", imem_addr,           16'h0000);
    check_eq("t5_drop_val2",  {15'b0, inst_valid}, 16'h0000);
    next_cycle();
    check_eq("t5_new_req",  {15'b0, imem_req}, 16'h0001);
    check_eq("t5_new_addr", imem_addr,         16'h0200);
    wait_valid("t5_wait_valid");
    check_eq("t5_inst",  inst_out,     16'hA200);
    check_eq("t5_pcadd", pc_added_out, 16'h0201);

    // Asynchronous reset while in DROP.
    do_reset(3);
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    next_cycle();
    redirect = 1'b0;
    check_eq("t6_drop_addr", imem_addr, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_req",   {15'b0, imem_req},   16'h0000);
    check_eq("t6_rst_valid", {15'b0, inst_valid}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t6_first_req",  {15'b0, imem_req}, 16'h0001);
    check_eq("t6_first_addr", imem_addr,         16'h0000);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_eq("t6_no_stale", {15'b0, inst_valid}, 16'h0000);
    end
    next_cycle();
    check_eq("t6_valid", {15'b0, inst_valid}, 16'h0001);
    check_eq("t6_inst",  inst_out,            16'hA000);
    check_eq("t6_pcadd", pc_added_out,        16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
